// File: rtl/mux_rr_nx1.sv
`timescale 1ns/1ps
// mux_rr_nx1: N-channel registered multiplexer with per-channel valid/ready.
// Round-robin or fixed-select arbitration feeds a single output register.
module mux_rr_nx1 #(
   parameter int N = 8,
   parameter int W = 8,
   parameter int S = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic           mode,
   input  logic [S-1:0]   fixed_sel,
   output logic [W-1:0]   out_data,
   output logic [S-1:0]   out_chan,
   output logic           out_valid,
   input  logic           out_ready
);
   // One extra bit so ptr + offset and the N compare never overflow.
   localparam logic [S:0] N_EXT = (S+1)'(N);
   localparam logic [S:0] LAST  = (S+1)'(N-1);

   logic [S-1:0] ptr;
   logic         load_en;
   logic         gnt_vld;
   logic [S-1:0] gnt;
   logic [S:0]   scan;

   // rst_n in the term keeps in_ready low for the whole reset window.
   assign load_en = rst_n && (!out_valid || out_ready);

   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      scan    = '0;
      if (mode) begin
         if (({1'b0, fixed_sel} < N_EXT) && in_valid[fixed_sel]) begin
            gnt_vld = 1'b1;
            gnt     = fixed_sel;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr} + (S+1)'(k);
            if (scan >= N_EXT) scan = scan - N_EXT;
            if (!gnt_vld && in_valid[scan[S-1:0]]) begin
               gnt_vld = 1'b1;
               gnt     = scan[S-1:0];
            end
         end
      end
   end

   assign in_ready = (gnt_vld && load_en) ? (N'(1) << gnt) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (gnt_vld) begin
            out_data  <= in_data[int'(gnt)*W +: W];
            out_chan  <= gnt;
            out_valid <= 1'b1;
            if (!mode) ptr <= ({1'b0, gnt} == LAST) ? '0 : gnt + S'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
